// File: rtl/hazard_detect_unit_if.sv
// Pipeline hazard bus: ID/EX/MEM hazard sources in, stall/flush controls and stall counter out.
interface hazard_detect_unit_if;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRt;
    logic        ID_Branch;
    logic        ID_Jump;
    logic        ID_JumpSRC;
    logic        ID_Taken;
    logic [1:0]  EX_MemRead;
    logic [1:0]  MEM_MemRead;
    logic        EX_RegWrite;
    logic [4:0]  EX_WAddr;
    logic [4:0]  MEM_WAddr;
    logic        IDStall;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic [15:0] StallCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_Jump, ID_JumpSRC, ID_Taken,
               EX_MemRead, MEM_MemRead, EX_RegWrite, EX_WAddr, MEM_WAddr,
        input  IDStall, PCWrite, IFIDWrite, IFIDFlush, StallCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_Jump, ID_JumpSRC, ID_Taken,
               EX_MemRead, MEM_MemRead, EX_RegWrite, EX_WAddr, MEM_WAddr,
        output IDStall, PCWrite, IFIDWrite, IFIDFlush, StallCount
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard detection: load-use and branch/jr operand stalls, taken-transfer flush.
// Optional stall-cycle performance counter enabled by macro HAZARD_PERF_EN.
module hazard_detect_unit (
    input  logic                 Clk,
    input  logic                 Rst,
    hazard_detect_unit_if.slave  hz
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t state;
    state_t state_next;
    logic   match_ex;
    logic   match_mem;
    logic   ctl;
    logic   ex_load;
    logic   mem_load;
    logic   haz1;
    logic   haz2;
    logic   stall;

    // Register 0 is hardwired zero and never produces a dependency.
    assign match_ex  = (hz.EX_WAddr != 5'd0) &&
                       ((hz.EX_WAddr == hz.ID_Rs) || (hz.ID_UsesRt && (hz.EX_WAddr == hz.ID_Rt)));
    assign match_mem = (hz.MEM_WAddr != 5'd0) &&
                       ((hz.MEM_WAddr == hz.ID_Rs) || (hz.ID_UsesRt && (hz.MEM_WAddr == hz.ID_Rt)));
    assign ctl       = hz.ID_Branch || (hz.ID_Jump && hz.ID_JumpSRC);
    assign ex_load   = (hz.EX_MemRead != 2'b00);
    assign mem_load  = (hz.MEM_MemRead != 2'b00);

    // Two-cycle case: a branch/jr needs a value still being loaded in EX.
    assign haz2 = ctl && ex_load && match_ex;
    assign haz1 = (ex_load && match_ex) ||
                  (ctl && hz.EX_RegWrite && !ex_load && match_ex) ||
                  (ctl && mem_load && match_mem);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = haz1 || haz2;
                if (haz2) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset forces every control low; stall overrides a simultaneous taken flush.
    assign hz.IDStall   = Rst && stall;
    assign hz.PCWrite   = Rst && !stall;
    assign hz.IFIDWrite = Rst && !stall;
    assign hz.IFIDFlush = Rst && hz.ID_Taken && !stall;

`ifdef HAZARD_PERF_EN
    localparam int unsigned CntW = 16;

    logic [CntW-1:0] stall_count;

    // Saturating count of stalled cycles.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_count <= '0;
        end else if (hz.IDStall && (stall_count != {CntW{1'b1}})) begin
            stall_count <= stall_count + CntW'(1);
        end
    end

    assign hz.StallCount = stall_count;
`else
    assign hz.StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed self-checking bench for hazard_detect_unit (both HAZARD_PERF_EN builds).
module tb_hazard_detect_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [15:0] model_cnt;

    hazard_detect_unit_if hz ();

    hazard_detect_unit dut (
        .Clk (clk),
        .Rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; model the counter from the stall the bench expects.
    task automatic tick(input logic exp_stall);
        if (!rst) begin
            model_cnt = 16'h0000;
        end else if (exp_stall && (model_cnt != 16'hFFFF)) begin
            model_cnt = model_cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef HAZARD_PERF_EN
        return model_cnt;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic clear();
        hz.ID_Rs       = 5'd0;
        hz.ID_Rt       = 5'd0;
        hz.ID_UsesRt   = 1'b0;
        hz.ID_Branch   = 1'b0;
        hz.ID_Jump     = 1'b0;
        hz.ID_JumpSRC  = 1'b0;
        hz.ID_Taken    = 1'b0;
        hz.EX_MemRead  = 2'b00;
        hz.MEM_MemRead = 2'b00;
        hz.EX_RegWrite = 1'b0;
        hz.EX_WAddr    = 5'd0;
        hz.MEM_WAddr   = 5'd0;
    endtask

    task automatic check_ctl(input string tag, input logic stall, input logic flush);
        check({tag, "_stall"}, 32'(hz.IDStall), 32'(stall));
        check({tag, "_pcw"}, 32'(hz.PCWrite), 32'(!stall));
        check({tag, "_ifidw"}, 32'(hz.IFIDWrite), 32'(!stall));
        check({tag, "_flush"}, 32'(hz.IFIDFlush), 32'(flush));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        model_cnt = 16'h0000;

        // Reset forces outputs low even with a hazard and taken present
        clear();
        rst           = 1'b0;
        hz.ID_Taken   = 1'b1;
        hz.EX_MemRead = 2'b11;
        hz.EX_WAddr   = 5'd8;
        hz.ID_Rs      = 5'd8;
        #1;
        check("rst_stall", 32'(hz.IDStall), 32'd0);
        check("rst_pcw", 32'(hz.PCWrite), 32'd0);
        check("rst_ifidw", 32'(hz.IFIDWrite), 32'd0);
        check("rst_flush", 32'(hz.IFIDFlush), 32'd0);
        tick(1'b0);
        tick(1'b0);
        check("rst_cnt", 32'(hz.StallCount), 32'(exp_cnt()));

        clear();
        rst = 1'b1;
        #1 check_ctl("idle", 1'b0, 1'b0);
        tick(1'b0);

        // Load-use on Rs
        hz.EX_MemRead = 2'b11;
        hz.EX_WAddr   = 5'd8;
        hz.ID_Rs      = 5'd8;
        #1 check_ctl("lu", 1'b1, 1'b0);
        tick(1'b1);
        hz.EX_MemRead = 2'b00;
        #1 check_ctl("lu_done", 1'b0, 1'b0);
        tick(1'b0);

        // Rt only counts when ID reads Rt
        clear();
        hz.EX_MemRead = 2'b10;
        hz.EX_WAddr   = 5'd9;
        hz.ID_Rt      = 5'd9;
        hz.ID_Rs      = 5'd3;
        #1 check("lu_rt_unused", 32'(hz.IDStall), 32'd0);
        hz.ID_UsesRt = 1'b1;
        #1 check("lu_rt_used", 32'(hz.IDStall), 32'd1);
        tick(1'b1);

        // Register 0 never hazards
        clear();
        hz.EX_MemRead = 2'b11;
        #1 check_ctl("r0", 1'b0, 1'b0);
        tick(1'b0);

        // Branch on EX load: two stall cycles even when inputs clear
        clear();
        hz.ID_Branch  = 1'b1;
        hz.EX_MemRead = 2'b01;
        hz.EX_WAddr   = 5'd5;
        hz.ID_Rt      = 5'd5;
        hz.ID_UsesRt  = 1'b1;
        #1 check_ctl("br_ld_c1", 1'b1, 1'b0);
        tick(1'b1);
        clear();
        hz.ID_Taken = 1'b1;
        #1 check_ctl("br_ld_c2", 1'b1, 1'b0);
        tick(1'b1);
        #1 check_ctl("br_ld_c3", 1'b0, 1'b1);
        tick(1'b0);

        // jr on an EX ALU result: one cycle, stall beats taken
        clear();
        hz.ID_Jump     = 1'b1;
        hz.ID_JumpSRC  = 1'b1;
        hz.EX_RegWrite = 1'b1;
        hz.EX_WAddr    = 5'd7;
        hz.ID_Rs       = 5'd7;
        hz.ID_Taken    = 1'b1;
        #1 check_ctl("jr_alu", 1'b1, 1'b0);
        tick(1'b1);
        clear();
        hz.ID_Taken = 1'b1;
        #1 check_ctl("jr_alu_next", 1'b0, 1'b1);
        tick(1'b0);

        // Direct jump and non-control instructions ignore EX ALU results
        clear();
        hz.ID_Jump     = 1'b1;
        hz.EX_RegWrite = 1'b1;
        hz.EX_WAddr    = 5'd7;
        hz.ID_Rs       = 5'd7;
        #1 check("j_direct", 32'(hz.IDStall), 32'd0);
        hz.ID_Jump = 1'b0;
        #1 check("alu_noctl", 32'(hz.IDStall), 32'd0);
        tick(1'b0);

        // Branch on MEM load: one cycle
        clear();
        hz.MEM_MemRead = 2'b10;
        hz.MEM_WAddr   = 5'd12;
        hz.ID_Rs       = 5'd12;
        #1 check("mem_noctl", 32'(hz.IDStall), 32'd0);
        hz.ID_Branch = 1'b1;
        #1 check("br_mem", 32'(hz.IDStall), 32'd1);
        tick(1'b1);
        hz.MEM_MemRead = 2'b00;
        #1 check("br_mem_next", 32'(hz.IDStall), 32'd0);
        tick(1'b0);
        check("cnt_pre", 32'(hz.StallCount), 32'(exp_cnt()));

        // Reset during HOLD
        clear();
        hz.ID_Branch  = 1'b1;
        hz.EX_MemRead = 2'b11;
        hz.EX_WAddr   = 5'd4;
        hz.ID_Rs      = 5'd4;
        #1 check("rsth_c1", 32'(hz.IDStall), 32'd1);
        tick(1'b1);
        clear();
        #1 check("rsth_hold", 32'(hz.IDStall), 32'd1);
        rst = 1'b0;
        #1;
        check("rsth_stall", 32'(hz.IDStall), 32'd0);
        check("rsth_pcw", 32'(hz.PCWrite), 32'd0);
        tick(1'b0);
        check("rsth_cnt", 32'(hz.StallCount), 32'(exp_cnt()));
        rst = 1'b1;
        #1 check_ctl("rsth_rel", 1'b0, 1'b0);
        tick(1'b0);

`ifdef HAZARD_PERF_EN
        // Saturation: drive the counter to 0xFFFE, then three more stalls
        check("sat_start", 32'(hz.StallCount), 32'd0);
        hz.EX_MemRead = 2'b11;
        hz.EX_WAddr   = 5'd8;
        hz.ID_Rs      = 5'd8;
        for (int i = 0; i < 65534; i++) tick(1'b1);
        check("sat_fffe", 32'(hz.StallCount), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) tick(1'b1);
        check("sat_ffff", 32'(hz.StallCount), 32'h0000FFFF);
        clear();
        #1 check("sat_idle", 32'(hz.IDStall), 32'd0);
`else
        check("cnt_tied", 32'(hz.StallCount), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port Rst, input, 1, synchronous active-low reset, sampled on the Clk rising edge.
REQ-003 SHALL have ports ID_Rs, ID_Rt, input, 5 each, source register numbers of the instruction in ID.
REQ-004 SHALL have port ID_UsesRt, input, 1, high when the ID instruction reads Rt.
REQ-005 SHALL have ports ID_Branch, ID_Jump, ID_JumpSRC, input, 1 each, ID control (JumpSRC=1 means register jump, jr).
REQ-006 SHALL have port ID_Taken, input, 1, branch or jump in ID resolved taken this cycle.
REQ-007 SHALL have ports EX_MemRead, MEM_MemRead, input, 2 each, load-size codes of the EX and MEM instructions (non-zero means load).
REQ-008 SHALL have ports EX_RegWrite, input, 1, and EX_WAddr, MEM_WAddr, input, 5 each, destination registers.
REQ-009 SHALL have port IDStall, output, 1, drives the downstream control-zeroing mux (bubble into EX).
REQ-010 SHALL have ports PCWrite, IFIDWrite, output, 1 each, PC and IF/ID register enables.
REQ-011 SHALL have port IFIDFlush, output, 1, clears IF/ID on a taken control transfer.
REQ-012 SHALL have port StallCount, output, 16, count of stall cycles.

Function
REQ-013 SHALL define match(X) = (X != 0) and (X == ID_Rs or (ID_UsesRt and X == ID_Rt)); register 0 never creates a hazard.
REQ-014 SHALL define CTL = ID_Branch or (ID_Jump and ID_JumpSRC).
REQ-015 SHALL raise a 1-cycle hazard for a load-use case: EX_MemRead != 0 and match(EX_WAddr).
REQ-016 SHALL raise a 1-cycle hazard when CTL, EX_RegWrite, EX_MemRead == 0, and match(EX_WAddr) all hold.
REQ-017 SHALL raise a 2-cycle hazard when CTL, EX_MemRead != 0, and match(EX_WAddr) all hold; this takes priority over REQ-015.
REQ-018 SHALL raise a 1-cycle hazard when CTL, MEM_MemRead != 0, and match(MEM_WAddr) all hold.
REQ-019 SHALL implement a state machine with states IDLE and HOLD; reset state is IDLE.
REQ-020 SHALL, in IDLE, drive IDStall combinationally and in the same cycle as any hazard is detected (zero latency).
REQ-021 SHALL transition IDLE to HOLD only on a 2-cycle hazard; all other cases remain in IDLE and re-evaluate next cycle.
REQ-022 SHALL, in HOLD, assert IDStall unconditionally for exactly one cycle, ignore all inputs, and return to IDLE.
REQ-023 SHALL drive PCWrite = IFIDWrite = not IDStall whenever Rst is high.
REQ-024 SHALL assert IFIDFlush = ID_Taken and not IDStall; stall wins on simultaneous stall and taken, and flush is suppressed in HOLD.
REQ-025 SHALL increment StallCount on every rising edge with IDStall high, saturating at 0xFFFF with no wrap.

Reset
REQ-026 SHALL, while Rst is low, force IDStall=0, PCWrite=0, IFIDWrite=0, and IFIDFlush=0 combinationally.
REQ-027 SHALL, on a rising edge with Rst low, set state=IDLE and StallCount=0, including when reset occurs in HOLD.
REQ-028 SHALL, on the first edge after Rst returns high, evaluate hazards from IDLE with no residual stall.

Configuration
REQ-029 SHALL gate the stall counter with macro HAZARD_PERF_EN.
REQ-030 SHALL, with HAZARD_PERF_EN defined, implement StallCount per REQ-025 and REQ-027.
REQ-031 SHALL, with HAZARD_PERF_EN undefined, instantiate no counter register and tie StallCount to 16'h0000.
REQ-032 SHALL leave the port list and all other behaviour identical in both configurations.

Verification
REQ-033 SHALL cover load-use: EX_MemRead=2'b11, EX_WAddr=8, ID_Rs=8, CTL=0 -> IDStall=1 and PCWrite=0 for one cycle, then 0 after EX_MemRead=0.
REQ-034 SHALL cover branch on an EX load: ID_Branch=1, EX_MemRead=2'b01, EX_WAddr=5, ID_Rt=5, ID_UsesRt=1 -> IDStall=1 for exactly 2 cycles (IDLE then HOLD), even if inputs clear in cycle 2.
REQ-035 SHALL cover register 0: EX_MemRead=2'b11, EX_WAddr=0, ID_Rs=0 -> IDStall=0, PCWrite=1.
REQ-036 SHALL cover simultaneous events: ID_Taken=1 with a REQ-016 hazard -> IFIDFlush=0, IDStall=1; next cycle with no hazard -> IFIDFlush=1.
REQ-037 SHALL cover reset mid-stall: Rst=0 during HOLD -> IDStall=0 at once, state IDLE, and StallCount=0 after the edge.
REQ-038 SHALL cover saturation (HAZARD_PERF_EN defined): StallCount preloaded to 0xFFFE, 3 stall cycles -> StallCount=0xFFFF.
